// File: rtl/pattern_sequencer.sv
// pattern_sequencer: frame/line timing sequencer that steps a 4-entry pattern configuration table
//   clk, rst_n             : clock, asynchronous active-low reset
//   start, stop            : begin sequencing (IDLE only) / halt at next frame end (while busy)
//   cfg_we/cfg_addr/cfg_data : configuration table write port
//   cfg_last               : last table index in the rotation, captured at each frame start
//   f_sync, sync           : frame-start and line-start pulses
//   Mode/X/Y/constVal      : registered pattern configuration
//   cur_entry              : table index currently driving the configuration outputs
//   busy, frame_done       : not-IDLE flag, end-of-frame pulse
module pattern_sequencer #(
    parameter int LINE_CYCLES     = 4096,
    parameter int LINES_PER_FRAME = 32,
    parameter int BLANK_CYCLES    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [18:0] cfg_data,
    input  logic [1:0]  cfg_last,
    output logic        f_sync,
    output logic        sync,
    output logic [2:0]  Mode,
    output logic [1:0]  X,
    output logic [1:0]  Y,
    output logic [11:0] constVal,
    output logic [1:0]  cur_entry,
    output logic        busy,
    output logic        frame_done
);
    // One cycle counter serves both ACTIVE and HBLANK, so size it for the longer of the two.
    localparam int CMAX = (LINE_CYCLES > BLANK_CYCLES) ? LINE_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam int LW   = $clog2(LINES_PER_FRAME) + 1;

    typedef enum logic [2:0] {IDLE, FSTART, LSYNC, ACTIVE, HBLANK} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cyc;
    logic [LW-1:0] line;
    logic [1:0]    ptr, last;
    logic          stop_pending;
    logic [18:0]   tbl [4];
    logic          active_end, blank_end, line_last, frame_end, halt;

    assign active_end = state == ACTIVE && cyc == CW'(LINE_CYCLES - 1);
    assign blank_end  = state == HBLANK && cyc == CW'(BLANK_CYCLES - 1);
    assign line_last  = line == LW'(LINES_PER_FRAME - 1);
    assign frame_end  = blank_end && line_last;
    // A stop arriving in the very last cycle of a frame still halts at that frame end.
    assign halt       = stop_pending | stop;

    assign f_sync     = state == FSTART;
    assign sync       = state == LSYNC;
    assign busy       = state != IDLE;
    assign frame_done = frame_end;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? FSTART : IDLE;
            FSTART:  state_nxt = LSYNC;
            LSYNC:   state_nxt = ACTIVE;
            ACTIVE:  state_nxt = active_end ? HBLANK : ACTIVE;
            HBLANK:  state_nxt = !blank_end ? HBLANK : !line_last ? LSYNC : halt ? IDLE : FSTART;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cyc          <= '0;
            line         <= '0;
            ptr          <= '0;
            last         <= '0;
            stop_pending <= 1'b0;
            Mode         <= '0;
            X            <= '0;
            Y            <= '0;
            constVal     <= '0;
            cur_entry    <= '0;
            for (int i = 0; i < 4; i++) tbl[i] <= '0;
        end else begin
            state <= state_nxt;
            if (cfg_we) tbl[cfg_addr] <= cfg_data;
            // Counter restarts on every state change and only advances while dwelling in ACTIVE/HBLANK.
            cyc <= (state_nxt == state && (state == ACTIVE || state == HBLANK)) ? cyc + CW'(1) : '0;
            if (busy && state_nxt == IDLE)
                stop_pending <= 1'b0;
            else if (busy && stop)
                stop_pending <= 1'b1;
            if (state == IDLE && start) ptr <= '0;
            if (state == FSTART) begin
                {Mode, X, Y, constVal} <= tbl[ptr];
                cur_entry              <= ptr;
                last                   <= cfg_last;
                line                   <= '0;
            end
            if (blank_end && !line_last) line <= line + LW'(1);
            // ">=" also wraps when cfg_last was lowered below the current pointer.
            if (frame_end && !halt) ptr <= (ptr >= last) ? 2'd0 : ptr + 2'd1;
        end
    end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed self-checking bench with a frame-configuration scoreboard
module tb_pattern_sequencer;
    logic        clk, rst_n, start, stop, cfg_we;
    logic [1:0]  cfg_addr, cfg_last;
    logic [18:0] cfg_data;
    logic        f_sync, sync, busy, frame_done;
    logic [2:0]  Mode;
    logic [1:0]  X, Y, cur_entry;
    logic [11:0] constVal;

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q [$];

    pattern_sequencer #(.LINE_CYCLES(8), .LINES_PER_FRAME(2), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_last(cfg_last),
        .f_sync(f_sync), .sync(sync), .Mode(Mode), .X(X), .Y(Y), .constVal(constVal),
        .cur_entry(cur_entry), .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_cfg(input logic [1:0] a, input logic [18:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fsync"}, 32'(f_sync), 0);
        chk({tag, "_sync"}, 32'(sync), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_fdone"}, 32'(frame_done), 0);
        chk({tag, "_cfg"}, 32'({Mode, X, Y, constVal, cur_entry}), 0);
    endtask

    // Scoreboard/monitor: the cycle after each f_sync pops the expected configuration;
    // each frame_done checks frame length and line-sync count.
    logic fs_d = 1'b0;
    int   syncs = 0;
    int   flen = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            fs_d = 1'b0; syncs = 0; flen = 0;
        end else begin
            chk("mon_fsync_and_sync", 32'(f_sync & sync), 0);
            if (fs_d) begin
                if (exp_q.size() == 0) chk("mon_unexpected_frame", 1, 0);
                else chk("mon_cfg", 32'({Mode, X, Y, constVal, cur_entry}), 32'(exp_q.pop_front()));
            end
            fs_d = f_sync;
            if (f_sync) begin syncs = 0; flen = 0; end else flen++;
            if (sync) syncs++;
            if (frame_done) begin
                chk("mon_sync_count", 32'(syncs), 2);
                chk("mon_frame_len", 32'(flen), 22);
            end
        end
    end

    localparam logic [18:0] E_A  = {3'd1, 2'd0, 2'd0, 12'h123};
    localparam logic [18:0] E0   = {3'd2, 2'd1, 2'd2, 12'hABC};
    localparam logic [18:0] E1   = {3'd3, 2'd2, 2'd1, 12'h456};
    localparam logic [18:0] E2   = {3'd4, 2'd3, 2'd3, 12'hFED};
    localparam logic [18:0] E0N  = {3'd5, 2'd0, 2'd1, 12'h777};

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0; cfg_last = '0;
        step(); step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();
        chk_zero("idle");

        // Basic frame timing, start held high while busy, stop at cycle 5 of second frame.
        write_cfg(2'd0, E_A);
        cfg_last = 2'd0;
        exp_q.push_back({E_A, 2'd0});
        exp_q.push_back({E_A, 2'd0});
        start = 1'b1;
        step();
        for (int n = 1; n <= 52; n++) begin
            chk("A_fsync", 32'(f_sync), 32'(n == 1 || n == 24));
            chk("A_sync", 32'(sync), 32'(n == 2 || n == 13 || n == 25 || n == 36));
            chk("A_fdone", 32'(frame_done), 32'(n == 23 || n == 46));
            chk("A_busy", 32'(busy), 32'(n <= 46));
            chk("A_mode", 32'(Mode), n >= 2 ? 1 : 0);
            chk("A_const", 32'(constVal), n >= 2 ? 32'h123 : 0);
            start = (n <= 40);
            stop  = (n == 28);
            step();
        end

        // Rotation 0,1,2 with mid-frame rewrite of entry 0 and cfg_last dropped to 0.
        write_cfg(2'd0, E0);
        write_cfg(2'd1, E1);
        write_cfg(2'd2, E2);
        cfg_last = 2'd2;
        exp_q.push_back({E0, 2'd0});
        exp_q.push_back({E1, 2'd1});
        exp_q.push_back({E2, 2'd2});
        exp_q.push_back({E0N, 2'd0});
        exp_q.push_back({E0N, 2'd0});
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 125; t++) begin
            cfg_we = (t == 5); cfg_addr = 2'd0; cfg_data = E0N;
            if (t == 30) cfg_last = 2'd0;
            stop = (t == 96);
            if (t == 10) chk("B_hold_mode", 32'({Mode, X, Y, constVal}), 32'(E0));
            if (t == 115) chk("B_fdone", 32'(frame_done), 1);
            if (t == 115) chk("B_busy_last", 32'(busy), 1);
            if (t == 116) chk("B_idle", 32'(busy), 0);
            if (t == 120) chk("B_no_restart", 32'(f_sync), 0);
            step();
        end

        // Reset during ACTIVE aborts immediately and clears the table.
        exp_q.push_back({E0N, 2'd0});
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t < 5; t++) step();
        chk("C_pre_busy", 32'(busy), 1);
        #1 rst_n = 1'b0;
        #1 chk_zero("C_async");
        step();
        rst_n = 1'b1;
        step();
        chk_zero("C_after");
        exp_q.push_back({19'd0, 2'd0});
        start = 1'b1;
        step();
        start = 1'b0;
        for (int t = 1; t <= 26; t++) begin
            stop = (t == 3);
            if (t == 1) chk("C_fsync", 32'(f_sync), 1);
            if (t == 23) chk("C_fdone", 32'(frame_done), 1);
            if (t == 24) chk("C_idle", 32'(busy), 0);
            step();
        end

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
